// File: rtl/pwm_deadtime_gen_pkg.sv
// pwm_deadtime_gen_pkg: state encoding and default counter width for the dead-time generator
package pwm_deadtime_gen_pkg;
  localparam int DT_WIDTH = 16;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOW_ON  = 3'd1,
    DT_RISE = 3'd2,
    HIGH_ON = 3'd3,
    DT_FALL = 3'd4
`ifdef PWM_DT_FAULT_EN
    , FAULT = 3'd5
`endif
  } state_e;
endpackage

// File: rtl/pwm_dt_timer.sv
// pwm_dt_timer: loadable down-counter whose expire flag marks the last cycle of a dead-time interval (count==1)
module pwm_dt_timer
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int DtWidth = DT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [DtWidth-1:0] load_val_i,
  output logic               expire_o
);
  logic [DtWidth-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
  assign expire_o = cnt_q == DtWidth'(1);
endmodule

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary high/low drive with rise/fall dead time and short-pulse suppression; PWM_DT_FAULT_EN adds fault_i/fault_clear_i/fault_o
module pwm_deadtime_gen
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int DtWidth = DT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               pwm_i,
  input  logic [DtWidth-1:0] deadtime_rise_i,
  input  logic [DtWidth-1:0] deadtime_fall_i,
  input  logic               clear_i,
`ifdef PWM_DT_FAULT_EN
  input  logic               fault_i,
  input  logic               fault_clear_i,
  output logic               fault_o,
`endif
  output logic               pwm_high_o,
  output logic               pwm_low_o,
  output logic               dt_active_o,
  output logic [DtWidth-1:0] suppressed_cnt_o
);
  state_e state_q, state_d;
  logic [DtWidth-1:0] sup_q, sup_d, load_val;
  logic load, tmr_en, expire, inc;
  assign load_val = state_q == HIGH_ON ? deadtime_fall_i : deadtime_rise_i;
  pwm_dt_timer #(.DtWidth(DtWidth)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .en_i       (tmr_en),
    .load_val_i (load_val),
    .expire_o   (expire)
  );
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    tmr_en = 1'b0;
    inc = 1'b0;
`ifdef PWM_DT_FAULT_EN
    if (fault_i) state_d = FAULT;
    else if (state_q == FAULT) state_d = fault_clear_i ? IDLE : FAULT;
    else
`endif
    if (!enable_i) state_d = IDLE;
    else case (state_q)
      IDLE, LOW_ON: if (pwm_i || state_q == IDLE) begin
        state_d = !pwm_i ? LOW_ON : load_val == '0 ? HIGH_ON : DT_RISE;
        load = pwm_i;
      end
      HIGH_ON: if (!pwm_i) begin
        state_d = load_val == '0 ? LOW_ON : DT_FALL;
        load = 1'b1;
      end
      DT_RISE: begin
        state_d = expire ? HIGH_ON : pwm_i ? DT_RISE : LOW_ON;
        tmr_en = 1'b1;
        inc = !expire && !pwm_i;
      end
      DT_FALL: begin
        state_d = expire ? LOW_ON : pwm_i ? HIGH_ON : DT_FALL;
        tmr_en = 1'b1;
        inc = !expire && pwm_i;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb sup_d = clear_i ? '0 : (inc && sup_q != '1) ? sup_q + 1'b1 : sup_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sup_q <= '0;
    end else begin
      state_q <= state_d;
      sup_q <= sup_d;
    end
  end
  assign pwm_high_o = state_q == HIGH_ON;
  assign pwm_low_o = state_q == LOW_ON;
  assign dt_active_o = state_q == DT_RISE || state_q == DT_FALL;
  assign suppressed_cnt_o = sup_q;
`ifdef PWM_DT_FAULT_EN
  assign fault_o = state_q == FAULT;
`endif
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen: directed and random stimulus checked cycle by cycle against a behavioural drive model
module tb_pwm_deadtime_gen;
  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic pwm = 1'b0;
  logic clr = 1'b0;
  logic [W-1:0] rise = '0;
  logic [W-1:0] fall = '0;
  logic high, low, dt;
  logic [W-1:0] cnt;
  int total = 0;
  int bad = 0;
  int m_drive = 0;
  int m_pend = 0;
  bit m_goal = 1'b0;
  bit m_idle = 1'b1;
  int m_cnt = 0;
  bit m_fault = 1'b0;
`ifdef PWM_DT_FAULT_EN
  logic fault = 1'b0;
  logic fclr = 1'b0;
  logic fault_out;
`endif
  always #5 clk = ~clk;
  pwm_deadtime_gen #(.DtWidth(W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_i         (en),
    .pwm_i            (pwm),
    .deadtime_rise_i  (rise),
    .deadtime_fall_i  (fall),
    .clear_i          (clr),
`ifdef PWM_DT_FAULT_EN
    .fault_i          (fault),
    .fault_clear_i    (fclr),
    .fault_o          (fault_out),
`endif
    .pwm_high_o       (high),
    .pwm_low_o        (low),
    .dt_active_o      (dt),
    .suppressed_cnt_o (cnt)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  // m_drive: 0 off, 1 low, 2 high; m_pend: dead cycles left before the m_goal side turns on
  task automatic model_step();
    bit inc;
    bit done;
    int d;
    int want;
    inc = 1'b0;
    done = 1'b0;
    if (rst) begin
      m_drive = 0;
      m_pend = 0;
      m_idle = 1'b1;
      m_cnt = 0;
      m_fault = 1'b0;
      return;
    end
`ifdef PWM_DT_FAULT_EN
    if (fault) begin
      m_fault = 1'b1;
      m_drive = 0;
      m_pend = 0;
      done = 1'b1;
    end else if (m_fault) begin
      if (fclr) begin
        m_fault = 1'b0;
        m_idle = 1'b1;
      end
      done = 1'b1;
    end
`endif
    if (!done) begin
      if (!en) begin
        m_drive = 0;
        m_pend = 0;
        m_idle = 1'b1;
      end else if (m_pend > 0) begin
        if (m_pend == 1) begin
          m_drive = m_goal ? 2 : 1;
          m_pend = 0;
        end else if (pwm != m_goal) begin
          m_drive = m_goal ? 1 : 2;
          m_pend = 0;
          inc = 1'b1;
        end else m_pend--;
      end else begin
        want = pwm ? 2 : 1;
        if (m_idle && !pwm) begin
          m_drive = 1;
          m_idle = 1'b0;
        end else if (m_drive != want) begin
          d = pwm ? int'(rise) : int'(fall);
          m_idle = 1'b0;
          m_goal = pwm;
          if (d == 0) m_drive = want;
          else begin
            m_pend = d;
            m_drive = 0;
          end
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (inc && m_cnt < CMAX) m_cnt++;
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("high", 32'(high), 32'(m_drive == 2));
      chk("low", 32'(low), 32'(m_drive == 1));
      chk("dt_active", 32'(dt), 32'(m_pend > 0));
      chk("supp_cnt", 32'(cnt), 32'(m_cnt));
      chk("exclusive", 32'(high & low), 32'd0);
`ifdef PWM_DT_FAULT_EN
      chk("fault", 32'(fault_out), 32'(m_fault));
`endif
    end
  endtask
  initial begin
    int hold;
    hold = 0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    en = 1'b1;
    rise = 3;
    fall = 2;
    cyc(3);
    pwm = 1'b1;
    cyc(6);
    rise = 0;
    fall = 0;
    repeat (4) begin
      pwm = ~pwm;
      cyc(5);
    end
    fall = 4;
    pwm = 1'b1;
    cyc(3);
    pwm = 1'b0;
    cyc(2);
    pwm = 1'b1;
    cyc(3);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    rise = 4;
    pwm = 1'b0;
    cyc(8);
    pwm = 1'b1;
    cyc(4);
    pwm = 1'b0;
    cyc(8);
    pwm = 1'b1;
    cyc(3);
    pwm = 1'b0;
    cyc(8);
    pwm = 1'b1;
    cyc(2);
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(6);
    pwm = 1'b0;
    rise = 5;
    cyc(4);
    repeat (20) begin
      pwm = 1'b1;
      cyc(2);
      pwm = 1'b0;
      cyc(2);
    end
    pwm = 1'b1;
    cyc(2);
    pwm = 1'b0;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(3);
`ifdef PWM_DT_FAULT_EN
    rise = 1;
    pwm = 1'b1;
    cyc(4);
    fault = 1'b1;
    cyc(2);
    fclr = 1'b1;
    cyc(1);
    fault = 1'b0;
    cyc(1);
    fclr = 1'b0;
    pwm = 1'b0;
    cyc(3);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rise = W'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) fall = W'($urandom_range(0, 5));
      en = $urandom_range(0, 49) != 0;
      clr = $urandom_range(0, 199) == 0;
`ifdef PWM_DT_FAULT_EN
      fault = $urandom_range(0, 99) == 0;
      fclr = $urandom_range(0, 4) == 0;
`endif
      if (hold == 0) begin
        pwm = ~pwm;
        hold = $urandom_range(1, 8);
      end
      hold--;
      cyc(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream stage of the PWM mode generators (standard and heartbeat).
- Consumes the single-ended pwm_signal and drives a complementary high-side/low-side pair.
- Inserts independently programmable rising-edge and falling-edge dead times.
- Suppresses input pulses shorter than the dead time and counts them for software.

Parameters:
DtWidth, 16, width of the dead-time counts and of the suppressed-pulse counter.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
enable_i  input  1  channel enable; 0 forces both outputs low
pwm_i  input  1  PWM from the mode generator, same clock domain
deadtime_rise_i  input  DtWidth  cycles both outputs are off between low-off and high-on
deadtime_fall_i  input  DtWidth  cycles both outputs are off between high-off and low-on
clear_i  input  1  clears the suppressed-pulse counter
pwm_high_o  output  1  high-side drive
pwm_low_o  output  1  low-side drive
dt_active_o  output  1  1 while a dead-time interval is running
suppressed_cnt_o  output  DtWidth  saturating count of aborted dead-time intervals

Behaviour:
- Reset: state IDLE, counter 0, pwm_high_o=0, pwm_low_o=0, dt_active_o=0, suppressed_cnt_o=0.
- Outputs are Moore: decoded from the state register only. Output changes are visible one cycle after the edge that samples the cause.
- Output decode per state:
  - IDLE: 0/0.
  - LOW_ON: low=1.
  - DT_RISE: 0/0, dt_active=1.
  - HIGH_ON: high=1.
  - DT_FALL: 0/0, dt_active=1.
- pwm_high_o and pwm_low_o are never both 1 in any cycle.
- enable_i=0 has top priority (after reset): next state is IDLE from any state. Any dead-time interval in progress is discarded and not counted as suppressed.
- IDLE, enable_i=1:
  - pwm_i=0: go to LOW_ON.
  - pwm_i=1: go to DT_RISE and load the counter with deadtime_rise_i, or go directly to HIGH_ON if deadtime_rise_i=0.
- LOW_ON, pwm_i=1: go to DT_RISE and load the counter with deadtime_rise_i. If deadtime_rise_i=0, go directly to HIGH_ON (zero dead time allowed).
- DT_RISE:
  - Counter decrements each cycle.
  - Counter==1 with pwm_i=1: go to HIGH_ON. The high side therefore asserts exactly D cycles after the low side deasserts.
  - pwm_i=0 before expiry: return to LOW_ON and increment suppressed_cnt.
- HIGH_ON and DT_FALL mirror LOW_ON and DT_RISE, using deadtime_fall_i.
- Dead-time inputs are sampled only at counter load. Changes during an interval take effect at the next load.
- suppressed_cnt_o:
  - Saturates at all-ones.
  - clear_i has priority over a simultaneous increment; the result is 0.
- A pulse exactly D cycles wide passes. A pulse D-1 cycles wide is suppressed.

Optional Feature:
- Macro: PWM_DT_FAULT_EN.
- When defined:
  - Adds ports fault_i (input, 1) and fault_clear_i (input, 1), and fault_o (output, 1).
  - Adds a FAULT state.
  - fault_i=1 has priority over enable_i. The next state is FAULT from any state, and both drives go to 0 on the following cycle.
  - fault_o=1 while in FAULT.
  - FAULT exits to IDLE only when fault_clear_i=1 and fault_i=0 on the same edge.
  - Reset clears FAULT.
- When not defined: these ports and the FAULT state do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared PWM header/package: state encoding constants (IDLE, LOW_ON, DT_RISE, HIGH_ON, DT_FALL, FAULT) and the default DtWidth.
- One natural sub-module, pwm_dt_timer: a loadable DtWidth down-counter with load, enable, and an expire flag (count==1). It is reused for both dead-time directions.
- The FSM and the suppressed-pulse counter stay in the top module.

Test Plan:
- Reset, then enable_i=1, pwm_i=0, rise=3 → low=1 next cycle. Raise pwm_i → low=0 next cycle, high=1 exactly 3 cycles later, dt_active=1 for those 3 cycles.
- rise=fall=0, toggle pwm_i every 5 cycles → outputs are complementary with no gap, and never both 1.
- fall=4, high phase, pwm_i low for 2 cycles then high → both off 2 cycles, return to HIGH_ON, suppressed_cnt_o=1. Then pulse clear_i → 0.
- Pulse width equal to dead time (rise=4, pwm_i high for exactly 4 cycles) → high asserts; width 3 → suppressed.
- enable_i dropped mid DT_RISE → both 0 next cycle, suppressed_cnt unchanged. Re-enable with pwm_i=1 → full rise dead time before high.
- PWM_DT_FAULT_EN: fault_i during HIGH_ON → both 0 and fault_o=1 next cycle. fault_clear_i with fault_i still 1 → stays in FAULT. Clear with fault_i=0 → IDLE, then LOW_ON.
